// File: rtl/mem_stage.sv
// MEM-stage data-memory access controller.
// Lane steering, load formatting and a req/ack memory handshake with timeout.
module mem_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        breakpoint,
  input  logic        exmem_memread,
  input  logic        exmem_memwrite,
  input  logic [1:0]  exmem_size,
  input  logic        exmem_unsigned,
  input  logic [31:0] exmem_alu_out,
  input  logic [31:0] exmem_wdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] mem_dout,
  output logic        mem_stall,
  output logic        mem_misalign,
  output logic        mem_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [31:0] mem_dout_q, mem_dout_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;
  logic        ld_q, ld_d;
  logic [1:0]  lo_q, lo_d;
  logic [1:0]  sz_q, sz_d;
  logic        uns_q, uns_d;

  logic        aligned, mem_op, acc, start, expired;
  logic [3:0]  be_w;
  logic [31:0] wd_w;

  function automatic logic [31:0] fmt(
    input logic [31:0] rd,
    input logic [1:0]  lo,
    input logic [1:0]  sz,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{lo, 3'b000} +: 8];
    h = lo[1] ? rd[31:16] : rd[15:0];
    unique case (1'b1)
      sz == 2'b00: fmt = {{24{~uns & b[7]}}, b};
      sz == 2'b01: fmt = {{16{~uns & h[15]}}, h};
      default:     fmt = rd;
    endcase
  endfunction

  always_comb begin
    aligned = 1'b1;
    be_w    = 4'b1111;
    wd_w    = exmem_wdata;
    unique case (exmem_size)
      2'b00: begin
        be_w = 4'b0001 << exmem_alu_out[1:0];
        wd_w = {4{exmem_wdata[7:0]}};
      end
      2'b01: begin
        aligned = ~exmem_alu_out[0];
        be_w    = 4'b0011 << {exmem_alu_out[1], 1'b0};
        wd_w    = {2{exmem_wdata[15:0]}};
      end
      default: aligned = (exmem_alu_out[1:0] == 2'b00);
    endcase
  end

  assign mem_op  = exmem_memread | exmem_memwrite;
  assign acc     = mem_op & aligned;
  assign start   = acc & ~breakpoint;
  assign expired = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_be_q    <= '0;
      dm_wdata_q <= '0;
      mem_dout_q <= '0;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
      ld_q       <= 1'b0;
      lo_q       <= '0;
      sz_q       <= '0;
      uns_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_be_q    <= dm_be_d;
      dm_wdata_q <= dm_wdata_d;
      mem_dout_q <= mem_dout_d;
      mis_q      <= mis_d;
      err_q      <= err_d;
      ld_q       <= ld_d;
      lo_q       <= lo_d;
      sz_q       <= sz_d;
      uns_q      <= uns_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (dm_ack || expired) state_d = DONE;
      DONE:    if (!breakpoint) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_be_d    = dm_be_q;
    dm_wdata_d = dm_wdata_q;
    mem_dout_d = mem_dout_q;
    mis_d      = 1'b0;
    err_d      = err_q;
    ld_d       = ld_q;
    lo_d       = lo_q;
    sz_d       = sz_q;
    uns_d      = uns_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          dm_req_d   = 1'b1;
          dm_we_d    = exmem_memwrite;
          dm_addr_d  = {exmem_alu_out[31:2], 2'b00};
          dm_be_d    = exmem_memwrite ? be_w : 4'b0000;
          dm_wdata_d = wd_w;
          ld_d       = exmem_memread;
          lo_d       = exmem_alu_out[1:0];
          sz_d       = exmem_size;
          uns_d      = exmem_unsigned;
        end else if (mem_op && !aligned && !breakpoint) begin
          mis_d = 1'b1;
          if (exmem_memread) mem_dout_d = '0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // ack beats a simultaneous timeout
        if (dm_ack) begin
          dm_req_d = 1'b0;
          if (ld_q) mem_dout_d = fmt(dm_rdata, lo_q, sz_q, uns_q);
        end else if (expired) begin
          dm_req_d   = 1'b0;
          mem_dout_d = '0;
          err_d      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign mem_stall    = (state_q == BUSY) | ((state_q == IDLE) & acc);
  assign dm_req       = dm_req_q;
  assign dm_we        = dm_we_q;
  assign dm_addr      = dm_addr_q;
  assign dm_be        = dm_be_q;
  assign dm_wdata     = dm_wdata_q;
  assign mem_dout     = mem_dout_q;
  assign mem_misalign = mis_q;
  assign mem_err      = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage.
// Inputs change #1 after posedge; outputs sampled #1 later.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        breakpoint;
  logic        exmem_memread;
  logic        exmem_memwrite;
  logic [1:0]  exmem_size;
  logic        exmem_unsigned;
  logic [31:0] exmem_alu_out;
  logic [31:0] exmem_wdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [31:0] mem_dout;
  logic        mem_stall;
  logic        mem_misalign;
  logic        mem_err;

  int checks = 0;
  int errors = 0;
  int stalls;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .breakpoint(breakpoint),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .exmem_size(exmem_size), .exmem_unsigned(exmem_unsigned),
    .exmem_alu_out(exmem_alu_out), .exmem_wdata(exmem_wdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_dout(mem_dout), .mem_stall(mem_stall),
    .mem_misalign(mem_misalign), .mem_err(mem_err)
  );

  task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd);
    exmem_memread  = rd;
    exmem_memwrite = wr;
    exmem_size     = sz;
    exmem_unsigned = uns;
    exmem_alu_out  = a;
    exmem_wdata    = wd;
  endtask

  task automatic clr_op();
    set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // op already driven in IDLE; returns in DONE with op cleared
  task automatic run_access(input logic [31:0] rdata, input int waits, output int st);
    st = 0;
    #1;
    if (mem_stall) st++;
    tick();
    if (mem_stall) st++;
    repeat (waits) begin
      tick();
      if (mem_stall) st++;
    end
    dm_rdata = rdata;
    dm_ack   = 1'b1;
    tick();
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;
    clr_op();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; breakpoint = 1'b0; dm_ack = 1'b0; dm_rdata = 32'h0;
    clr_op();
    #12;
    checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", dm_req); end
    checks++; if (dm_addr !== 32'h0 || dm_be !== 4'h0 || dm_wdata !== 32'h0) begin errors++; $display("FAIL rst_dm got %h %h %h exp 0", dm_addr, dm_be, dm_wdata); end
    checks++; if (mem_dout !== 32'h0 || mem_err !== 1'b0 || mem_misalign !== 1'b0) begin errors++; $display("FAIL rst_out got %h %b %b exp 0", mem_dout, mem_err, mem_misalign); end
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lw();
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    #1;
    checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL lw_idle_req got %b exp 0", dm_req); end
    run_access(32'hDEADBEEF, 1, stalls);
    checks++; if (stalls !== 3) begin errors++; $display("FAIL lw_stall_cycles got %0d exp 3", stalls); end
    checks++; if (mem_dout !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_dout got %h exp deadbeef", mem_dout); end
    checks++; if (dm_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL lw_done got req %b stall %b exp 0 0", dm_req, mem_stall); end
    checks++; if (dm_addr !== 32'h100 || dm_be !== 4'h0 || dm_we !== 1'b0) begin errors++; $display("FAIL lw_dm got %h %h %b exp 100 0 0", dm_addr, dm_be, dm_we); end
    tick();
  endtask

  task automatic test_load_fmt();
    set_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    run_access(32'h80112233, 0, stalls);
    checks++; if (mem_dout !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_dout got %h exp ffffff80", mem_dout); end
    checks++; if (stalls !== 2) begin errors++; $display("FAIL lb_stall_cycles got %0d exp 2", stalls); end
    tick();
    set_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
    run_access(32'h80112233, 0, stalls);
    checks++; if (mem_dout !== 32'h00008011) begin errors++; $display("FAIL lhu_dout got %h exp 00008011", mem_dout); end
    tick();
    set_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    run_access(32'h80112233, 0, stalls);
    checks++; if (mem_dout !== 32'hFFFF8011) begin errors++; $display("FAIL lh_dout got %h exp ffff8011", mem_dout); end
    tick();
    set_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    run_access(32'h80112233, 0, stalls);
    checks++; if (mem_dout !== 32'h00000080) begin errors++; $display("FAIL lbu_dout got %h exp 00000080", mem_dout); end
    tick();
    set_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0);
    run_access(32'h80112233, 0, stalls);
    checks++; if (mem_dout !== 32'h00002233) begin errors++; $display("FAIL lh0_dout got %h exp 00002233", mem_dout); end
    tick();
  endtask

  task automatic test_store();
    set_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h000000AB);
    tick();
    checks++; if (dm_req !== 1'b1 || dm_we !== 1'b1) begin errors++; $display("FAIL sb_req got %b %b exp 1 1", dm_req, dm_we); end
    checks++; if (dm_be !== 4'b0010 || dm_wdata !== 32'hABABABAB || dm_addr !== 32'h100) begin errors++; $display("FAIL sb_lanes got %b %h %h exp 0010 abababab 100", dm_be, dm_wdata, dm_addr); end
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0; clr_op();
    tick();
    set_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000CAFE);
    tick();
    checks++; if (dm_be !== 4'b1100 || dm_wdata !== 32'hCAFECAFE) begin errors++; $display("FAIL sh_lanes got %b %h exp 1100 cafecafe", dm_be, dm_wdata); end
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0; clr_op();
    tick();
    set_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h104, 32'h11223344);
    tick();
    checks++; if (dm_be !== 4'b1111 || dm_wdata !== 32'h11223344 || dm_addr !== 32'h104) begin errors++; $display("FAIL sw_lanes got %b %h %h exp 1111 11223344 104", dm_be, dm_wdata, dm_addr); end
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0; clr_op();
    checks++; if (mem_dout !== 32'h00002233) begin errors++; $display("FAIL st_keeps_dout got %h exp 00002233", mem_dout); end
    tick();
  endtask

  task automatic test_misalign();
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
    #1;
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL mis_stall got %b exp 0", mem_stall); end
    tick();
    clr_op();
    checks++; if (mem_misalign !== 1'b1 || dm_req !== 1'b0 || mem_dout !== 32'h0) begin errors++; $display("FAIL mis_pulse got %b %b %h exp 1 0 0", mem_misalign, dm_req, mem_dout); end
    dm_ack = 1'b1; dm_rdata = 32'hFFFFFFFF;
    tick();
    checks++; if (mem_misalign !== 1'b0) begin errors++; $display("FAIL mis_end got %b exp 0", mem_misalign); end
    dm_ack = 1'b0; dm_rdata = 32'h0;
    tick();
    checks++; if (mem_dout !== 32'h0 || dm_req !== 1'b0) begin errors++; $display("FAIL idle_ack got %h %b exp 0 0", mem_dout, dm_req); end
  endtask

  task automatic test_timeout();
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h1F0, 32'h0);
    run_access(32'h13579BDF, 63, stalls);
    checks++; if (mem_dout !== 32'h13579BDF || mem_err !== 1'b0) begin errors++; $display("FAIL ack_at_expiry got %h %b exp 13579bdf 0", mem_dout, mem_err); end
    tick();
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    tick();
    repeat (63) tick();
    checks++; if (dm_req !== 1'b1 || mem_stall !== 1'b1 || mem_err !== 1'b0) begin errors++; $display("FAIL to_last_busy got %b %b %b exp 1 1 0", dm_req, mem_stall, mem_err); end
    tick();
    clr_op();
    checks++; if (dm_req !== 1'b0 || mem_err !== 1'b1 || mem_dout !== 32'h0 || mem_stall !== 1'b0) begin errors++; $display("FAIL to_abort got %b %b %h %b exp 0 1 0 0", dm_req, mem_err, mem_dout, mem_stall); end
    tick();
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h204, 32'h0);
    run_access(32'h0A0B0C0D, 2, stalls);
    checks++; if (mem_dout !== 32'h0A0B0C0D || mem_err !== 1'b1) begin errors++; $display("FAIL to_recover got %h %b exp 0a0b0c0d 1", mem_dout, mem_err); end
    tick();
  endtask

  task automatic test_breakpoint();
    breakpoint = 1'b1;
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    #1;
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL bp_stall got %b exp 1", mem_stall); end
    tick();
    tick();
    checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL bp_noreq got %b exp 0", dm_req); end
    breakpoint = 1'b0;
    tick();
    checks++; if (dm_req !== 1'b1) begin errors++; $display("FAIL bp_release_req got %b exp 1", dm_req); end
    breakpoint = 1'b1; dm_ack = 1'b1; dm_rdata = 32'h5A5A1234;
    tick();
    dm_ack = 1'b0; dm_rdata = 32'h0;
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h304, 32'h0);
    #1;
    checks++; if (mem_dout !== 32'h5A5A1234 || dm_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL bp_busy_done got %h %b %b exp 5a5a1234 0 0", mem_dout, dm_req, mem_stall); end
    tick();
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL bp_done_hold got %b exp 0", mem_stall); end
    breakpoint = 1'b0;
    tick();
    checks++; if (mem_stall !== 1'b1 || dm_req !== 1'b0) begin errors++; $display("FAIL bp_back_idle got %b %b exp 1 0", mem_stall, dm_req); end
    run_access(32'h0BADF00D, 0, stalls);
    checks++; if (mem_dout !== 32'h0BADF00D) begin errors++; $display("FAIL bp_next_load got %h exp 0badf00d", mem_dout); end
    tick();
  endtask

  task automatic test_reset_busy();
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    tick();
    checks++; if (dm_req !== 1'b1) begin errors++; $display("FAIL rb_req got %b exp 1", dm_req); end
    clr_op();
    rst_n = 1'b0;
    #1;
    checks++; if (dm_req !== 1'b0 || mem_stall !== 1'b0 || mem_err !== 1'b0 || mem_dout !== 32'h0) begin errors++; $display("FAIL rb_cleared got %b %b %b %h exp 0 0 0 0", dm_req, mem_stall, mem_err, mem_dout); end
    #2;
    rst_n = 1'b1;
    tick();
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h404, 32'h0);
    run_access(32'h24681357, 0, stalls);
    checks++; if (mem_dout !== 32'h24681357) begin errors++; $display("FAIL rb_after got %h exp 24681357", mem_dout); end
    tick();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_fmt();
    test_store();
    test_misalign();
    test_timeout();
    test_breakpoint();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
